mmio_host_master: RTL

MMIO_HOST_MASTER -- requirements
Module: mmio_host_master

---
 rtl/mmio_host_master_pkg.sv | 32 +++
 rtl/mmio_host_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_host_master_pkg.sv
// Shared definitions for the MMIO host master: bus widths, op encodings,
// the default CTRL register address, FSM state codes and a response helper.
package mmio_host_master_pkg;

  localparam int MMIO_ADDR_WIDTH = 32;
  localparam int MMIO_DATA_WIDTH = 64;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [MMIO_ADDR_WIDTH-1:0] MMIO_CTRL_ADDR = 32'h4000_0000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // A response belongs to the outstanding request only if both the command
  // type and the address echo back unchanged.
  function automatic logic resp_mismatch(
    input logic                       exp_cmd,
    input logic [MMIO_ADDR_WIDTH-1:0] exp_addr,
    input logic                       act_cmd,
    input logic [MMIO_ADDR_WIDTH-1:0] act_addr
  );
    return (exp_cmd != act_cmd) || (exp_addr != act_addr);
  endfunction

endpackage

// File: rtl/mmio_host_master.sv
// MMIO host master: turns READ / WRITE / START_POLL commands into a sequence
// of single-outstanding MMIO requests, streaming write data in and read data
// out, with sticky response, timeout and opcode error flags.
module mmio_host_master
  import mmio_host_master_pkg::*;
#(
  parameter logic [15:0]                TIMEOUT_CYCLES = 16'd65535,
  parameter logic [MMIO_ADDR_WIDTH-1:0] CTRL_ADDR      = MMIO_CTRL_ADDR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_val,
  output logic                       cmd_rdy,
  input  logic [1:0]                 cmd_op,
  input  logic [MMIO_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]                 cmd_len,
  input  logic                       wdata_val,
  output logic                       wdata_rdy,
  input  logic [MMIO_DATA_WIDTH-1:0] wdata,
  output logic                       rdata_val,
  input  logic                       rdata_rdy,
  output logic [MMIO_DATA_WIDTH-1:0] rdata,
  output logic                       req_cmd,
  output logic [MMIO_ADDR_WIDTH-1:0] req_addr,
  output logic [MMIO_DATA_WIDTH-1:0] req_data,
  output logic                       req_val,
  input  logic                       req_rdy,
  input  logic                       resp_cmd,
  input  logic [MMIO_ADDR_WIDTH-1:0] resp_addr,
  input  logic [MMIO_DATA_WIDTH-1:0] resp_data,
  input  logic                       resp_val,
  output logic                       resp_rdy,
  output logic                       busy,
  output logic                       done,
  output logic                       err_resp,
  output logic                       err_timeout,
  output logic                       err_op
);

  logic [2:0]                 state_r;
  logic [1:0]                 op_r;
  logic [8:0]                 cnt_r;
  logic                       poll_r;      // 0: CTRL write in flight, 1: status polling
  logic                       req_cmd_r;
  logic [MMIO_ADDR_WIDTH-1:0] req_addr_r;
  logic [MMIO_DATA_WIDTH-1:0] req_data_r;
  logic [MMIO_DATA_WIDTH-1:0] rdata_r;
  logic                       rdata_val_r;
  logic                       err_resp_r;
  logic                       err_timeout_r;
  logic                       err_op_r;
  logic [15:0]                tmo_r;

  logic        cmd_fire_s;
  logic        wdata_fire_s;
  logic        req_fire_s;
  logic        resp_rdy_s;
  logic        resp_fire_s;
  logic        rdata_fire_s;
  logic        read_hold_s;
  logic        last_s;
  logic        wait_s;
  logic        hs_s;
  logic [15:0] tmo_inc_s;
  logic        tmo_hit_s;

  // A READ may not accept another response (nor finish) while the previous
  // word still sits unconsumed in the rdata register.
  assign read_hold_s  = (op_r == OP_READ) && rdata_val_r;
  assign cmd_fire_s   = cmd_val && (state_r == ST_IDLE);
  assign wdata_fire_s = wdata_val && (state_r == ST_FETCH);
  assign req_fire_s   = req_rdy && (state_r == ST_REQ);
  assign resp_rdy_s   = (state_r == ST_RESP) && !read_hold_s;
  assign resp_fire_s  = resp_val && resp_rdy_s;
  assign rdata_fire_s = rdata_val_r && rdata_rdy;
  assign last_s       = (cnt_r == 9'd1);
  assign wait_s       = (state_r == ST_REQ) || (state_r == ST_RESP);
  assign hs_s         = req_fire_s || resp_fire_s;
  assign tmo_inc_s    = tmo_r + 16'd1;
  assign tmo_hit_s    = (TIMEOUT_CYCLES != 16'd0) && wait_s && !hs_s && (tmo_inc_s == TIMEOUT_CYCLES);

  assign cmd_rdy     = (state_r == ST_IDLE);
  assign wdata_rdy   = (state_r == ST_FETCH);
  assign req_val     = (state_r == ST_REQ);
  assign resp_rdy    = resp_rdy_s;
  assign busy        = (state_r != ST_IDLE);
  assign done        = (state_r == ST_DONE) && !read_hold_s;
  assign req_cmd     = req_cmd_r;
  assign req_addr    = req_addr_r;
  assign req_data    = req_data_r;
  assign rdata       = rdata_r;
  assign rdata_val   = rdata_val_r;
  assign err_resp    = err_resp_r;
  assign err_timeout = err_timeout_r;
  assign err_op      = err_op_r;

  // Idle-cycle counter for the current wait; saturates so it never re-hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_r <= 16'd0;
    end else if (!wait_s || hs_s) begin
      tmo_r <= 16'd0;
    end else if (tmo_r != 16'hFFFF) begin
      tmo_r <= tmo_inc_s;
    end
  end

  // Command sequencer with request, read-data and error-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      op_r          <= 2'b00;
      cnt_r         <= 9'd0;
      poll_r        <= 1'b0;
      req_cmd_r     <= 1'b0;
      req_addr_r    <= '0;
      req_data_r    <= '0;
      rdata_r       <= '0;
      rdata_val_r   <= 1'b0;
      err_resp_r    <= 1'b0;
      err_timeout_r <= 1'b0;
      err_op_r      <= 1'b0;
    end else begin
      if (rdata_fire_s) begin
        rdata_val_r <= 1'b0;
      end
      if (tmo_hit_s) begin
        err_timeout_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (cmd_fire_s) begin
            op_r          <= cmd_op;
            cnt_r         <= {1'b0, cmd_len} + 9'd1;
            poll_r        <= 1'b0;
            req_addr_r    <= cmd_addr;
            err_resp_r    <= 1'b0;
            err_timeout_r <= 1'b0;
            err_op_r      <= 1'b0;
            case (cmd_op)
              OP_READ: begin
                req_cmd_r <= 1'b0;
                state_r   <= ST_REQ;
              end
              OP_WRITE: begin
                req_cmd_r <= 1'b1;
                state_r   <= ST_FETCH;
              end
              OP_POLL: begin
                req_cmd_r  <= 1'b1;
                req_addr_r <= CTRL_ADDR;
                req_data_r <= 64'h1;
                state_r    <= ST_REQ;
              end
              default: begin
                err_op_r <= 1'b1;
                state_r  <= ST_DONE;
              end
            endcase
          end
        end
        ST_FETCH: begin
          if (wdata_fire_s) begin
            req_data_r <= wdata;
            state_r    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (req_fire_s) begin
            state_r <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_fire_s) begin
            if (resp_mismatch(req_cmd_r, req_addr_r, resp_cmd, resp_addr)) begin
              err_resp_r <= 1'b1;
            end
            case (op_r)
              OP_READ: begin
                rdata_r     <= resp_data;
                rdata_val_r <= 1'b1;
                cnt_r       <= cnt_r - 9'd1;
                if (last_s) begin
                  state_r <= ST_DONE;
                end else begin
                  req_addr_r <= req_addr_r + 32'd1;
                  state_r    <= ST_REQ;
                end
              end
              OP_WRITE: begin
                cnt_r <= cnt_r - 9'd1;
                if (last_s) begin
                  state_r <= ST_DONE;
                end else begin
                  req_addr_r <= req_addr_r + 32'd1;
                  state_r    <= ST_FETCH;
                end
              end
              OP_POLL: begin
                // First response acknowledges the CTRL write; afterwards
                // keep reading CTRL until its busy bit reads back clear.
                if (!poll_r) begin
                  poll_r    <= 1'b1;
                  req_cmd_r <= 1'b0;
                  state_r   <= ST_REQ;
                end else if (resp_data[0]) begin
                  state_r <= ST_REQ;
                end else begin
                  state_r <= ST_DONE;
                end
              end
              default: begin
                state_r <= ST_DONE;
              end
            endcase
          end
        end
        ST_DONE: begin
          if (!read_hold_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
